// File: rtl/gb_cpu_common_pkg.sv
// ---------------------------------------------------------------------------
// gb_cpu_common_pkg
// Shared register-file types for the Game Boy CPU core.
//   regfile_r8_t  : 8-bit register selector (also indexes regfile_t)
//   regfile_r16_t : 16-bit register-pair selector
//   regfile_t     : full register-file contents, one byte per regfile_r8_t
//   getRegisterHigh / getRegisterLow : map a pair to its high/low byte
// ---------------------------------------------------------------------------
package gb_cpu_common_pkg;

    typedef enum logic [3:0] {
        REG_B,
        REG_C,
        REG_D,
        REG_E,
        REG_H,
        REG_L,
        REG_A,
        REG_F,
        REG_IR,
        REG_IE,
        REG_TMP_L,
        REG_TMP_H,
        REG_SP_L,
        REG_SP_H,
        REG_PC_L,
        REG_PC_H
    } regfile_r8_t;

    typedef enum logic [2:0] {
        REG_BC,
        REG_DE,
        REG_HL,
        REG_AF,
        REG_SP,
        REG_PC,
        REG_TMP
    } regfile_r16_t;

    typedef logic [15:0][7:0] regfile_t;

    function automatic regfile_r8_t getRegisterHigh(input regfile_r16_t pair);
        regfile_r8_t r;
        case (pair)
            REG_BC:  r = REG_B;
            REG_DE:  r = REG_D;
            REG_HL:  r = REG_H;
            REG_AF:  r = REG_A;
            REG_SP:  r = REG_SP_H;
            REG_PC:  r = REG_PC_H;
            default: r = REG_TMP_H;
        endcase
        return r;
    endfunction

    function automatic regfile_r8_t getRegisterLow(input regfile_r16_t pair);
        regfile_r8_t r;
        case (pair)
            REG_BC:  r = REG_C;
            REG_DE:  r = REG_E;
            REG_HL:  r = REG_L;
            REG_AF:  r = REG_F;
            REG_SP:  r = REG_SP_L;
            REG_PC:  r = REG_PC_L;
            default: r = REG_TMP_L;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gb_cpu_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// gb_cpu_bus_ctrl_if
// Bundle of the request handshake, external memory bus and register-file
// write-back port of the CPU bus sequencer.
//   slave  : the sequencer side (gb_cpu_bus_ctrl)
//   master : the control unit / memory / register-file side
// ---------------------------------------------------------------------------
interface gb_cpu_bus_ctrl_if;
    import gb_cpu_common_pkg::*;

    // request from the control unit
    logic         req_valid;
    logic         req_write;
    regfile_r16_t req_addr_sel;
    regfile_r8_t  req_data_sel;
    regfile_r8_t  req_dest;
    logic         req_ready;

    // external bus
    logic [15:0]  bus_addr;
    logic [7:0]   bus_wdata;
    logic         bus_rd;
    logic         bus_wr;
    logic [7:0]   bus_rdata;

    // register-file write-back and status
    regfile_r8_t  data_bus_req;
    logic [7:0]   data_bus_data;
    logic         data_bus_wren;
    logic         done;
    logic         dest_err;

    modport slave (
        input  req_valid, req_write, req_addr_sel, req_data_sel, req_dest,
        input  bus_rdata,
        output req_ready,
        output bus_addr, bus_wdata, bus_rd, bus_wr,
        output data_bus_req, data_bus_data, data_bus_wren, done, dest_err
    );

    modport master (
        output req_valid, req_write, req_addr_sel, req_data_sel, req_dest,
        output bus_rdata,
        input  req_ready,
        input  bus_addr, bus_wdata, bus_rd, bus_wr,
        input  data_bus_req, data_bus_data, data_bus_wren, done, dest_err
    );

endinterface

// File: rtl/gb_cpu_bus_ctrl.sv
// ---------------------------------------------------------------------------
// gb_cpu_bus_ctrl
// Memory-bus sequencer: turns one access request per m-cycle into a
// four-T-cycle external bus transaction and returns read bytes to the
// register file.
// Ports:
//   clk       : T-cycle clock, all state changes on posedge
//   reset     : synchronous, active-high
//   registers : current register-file contents (address/data operands)
//   bus_if    : slave side of gb_cpu_bus_ctrl_if (request, bus, write-back)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction; ready for a request
// T1    | address driven, strobes low
// T2    | read or write strobe high
// T3    | strobe high; read data sampled on the edge leaving T3
// T4    | strobes low, done / write-back pulse; ready for next request
// ---------------------------------------------------------------------------
module gb_cpu_bus_ctrl
    import gb_cpu_common_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  regfile_t          registers,
    gb_cpu_bus_ctrl_if.slave  bus_if
);

    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        T3,
        T4
    } state_t;

    state_t      state_q;
    logic [15:0] bus_addr_q;
    logic [7:0]  wdata_lat_q;
    logic        write_q;
    regfile_r8_t dest_q;

    logic        bus_rd_q;
    logic        bus_wr_q;
    logic [7:0]  bus_wdata_q;
    regfile_r8_t data_bus_req_q;
    logic [7:0]  data_bus_data_q;
    logic        data_bus_wren_q;
    logic        done_q;
    logic        dest_err_q;

    // Operands as they stand on the accepting edge; latched so later
    // register-file writes cannot disturb the transaction in flight.
    logic [15:0] acc_addr_d;
    logic [7:0]  acc_wdata_d;
    logic        dest_legal_d;

    assign acc_addr_d   = {registers[getRegisterHigh(bus_if.req_addr_sel)],
                           registers[getRegisterLow(bus_if.req_addr_sel)]};
    assign acc_wdata_d  = registers[bus_if.req_data_sel];
    assign dest_legal_d = (dest_q == REG_IR) || (dest_q == REG_TMP_L) ||
                          (dest_q == REG_TMP_H);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            bus_addr_q      <= '0;
            wdata_lat_q     <= '0;
            write_q         <= 1'b0;
            dest_q          <= REG_IR;
            bus_rd_q        <= 1'b0;
            bus_wr_q        <= 1'b0;
            bus_wdata_q     <= '0;
            data_bus_req_q  <= REG_IR;
            data_bus_data_q <= '0;
            data_bus_wren_q <= 1'b0;
            done_q          <= 1'b0;
            dest_err_q      <= 1'b0;
        end else begin
            // single-cycle pulses default low, raised only entering T4
            done_q          <= 1'b0;
            data_bus_wren_q <= 1'b0;
            dest_err_q      <= 1'b0;

            case (state_q)
                IDLE, T4: begin
                    bus_rd_q    <= 1'b0;
                    bus_wr_q    <= 1'b0;
                    bus_wdata_q <= '0;
                    if (bus_if.req_valid) begin
                        bus_addr_q  <= acc_addr_d;
                        wdata_lat_q <= acc_wdata_d;
                        write_q     <= bus_if.req_write;
                        dest_q      <= bus_if.req_dest;
                        state_q     <= T1;
                    end else begin
                        state_q     <= IDLE;
                    end
                end
                T1: begin
                    bus_rd_q    <= ~write_q;
                    bus_wr_q    <= write_q;
                    bus_wdata_q <= write_q ? wdata_lat_q : 8'h00;
                    state_q     <= T2;
                end
                T2: begin
                    state_q <= T3;
                end
                T3: begin
                    bus_rd_q    <= 1'b0;
                    bus_wr_q    <= 1'b0;
                    bus_wdata_q <= '0;
                    done_q      <= 1'b1;
                    if (!write_q) begin
                        data_bus_data_q <= bus_if.bus_rdata;
                        if (dest_legal_d) begin
                            data_bus_wren_q <= 1'b1;
                            data_bus_req_q  <= dest_q;
                        end else begin
                            dest_err_q <= 1'b1;
                        end
                    end
                    state_q <= T4;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Ready depends on state only so the control unit can sample it
    // without a combinational loop through req_valid.
    assign bus_if.req_ready     = (state_q == IDLE) || (state_q == T4);
    assign bus_if.bus_addr      = bus_addr_q;
    assign bus_if.bus_wdata     = bus_wdata_q;
    assign bus_if.bus_rd        = bus_rd_q;
    assign bus_if.bus_wr        = bus_wr_q;
    assign bus_if.data_bus_req  = data_bus_req_q;
    assign bus_if.data_bus_data = data_bus_data_q;
    assign bus_if.data_bus_wren = data_bus_wren_q;
    assign bus_if.done          = done_q;
    assign bus_if.dest_err      = dest_err_q;

endmodule

// File: tb/tb_gb_cpu_bus_ctrl.sv
module tb_gb_cpu_bus_ctrl;
    import gb_cpu_common_pkg::*;

    logic     clk = 1'b0;
    logic     reset;
    regfile_t regs;

    gb_cpu_bus_ctrl_if bif();

    gb_cpu_bus_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .registers (regs),
        .bus_if    (bif)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Transaction-level model: one record for the access in flight plus its
    // age in T-cycles (1 = T1 ... 4 = T4) and the values the register file
    // last received.
    bit          m_act  = 1'b0;
    int          m_age  = 0;
    logic [15:0] m_addr = 16'h0000;
    logic [7:0]  m_wd   = 8'h00;
    bit          m_wr   = 1'b0;
    regfile_r8_t m_dest = REG_IR;
    logic [7:0]  m_dbd  = 8'h00;
    regfile_r8_t m_dbr  = REG_IR;
    bit          m_rdy;

    function automatic bit legal_dest(input regfile_r8_t d);
        return (d == REG_IR) || (d == REG_TMP_L) || (d == REG_TMP_H);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_act  = 1'b0;
            m_age  = 0;
            m_addr = 16'h0000;
            m_dbd  = 8'h00;
            m_dbr  = REG_IR;
        end else begin
            m_rdy = !m_act || (m_age == 4);
            if (m_act && m_age == 3 && !m_wr) begin
                m_dbd = bif.bus_rdata;
                if (legal_dest(m_dest)) m_dbr = m_dest;
            end
            if (m_act) m_age = m_age + 1;
            if (m_rdy) begin
                if (bif.req_valid) begin
                    m_act  = 1'b1;
                    m_age  = 1;
                    m_addr = {regs[getRegisterHigh(bif.req_addr_sel)],
                              regs[getRegisterLow(bif.req_addr_sel)]};
                    m_wd   = regs[bif.req_data_sel];
                    m_wr   = bif.req_write;
                    m_dest = bif.req_dest;
                end else begin
                    m_act = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic check_model();
        int  ph;
        bit  strobe;
        ph     = m_act ? m_age : 0;
        strobe = (ph == 2) || (ph == 3);
        chk("ready",    32'(bif.req_ready),     32'((ph == 0) || (ph == 4)));
        chk("bus_rd",   32'(bif.bus_rd),        32'(strobe && !m_wr));
        chk("bus_wr",   32'(bif.bus_wr),        32'(strobe && m_wr));
        chk("bus_wdata",32'(bif.bus_wdata),     32'((strobe && m_wr) ? m_wd : 8'h00));
        chk("bus_addr", 32'(bif.bus_addr),      32'(m_addr));
        chk("done",     32'(bif.done),          32'(ph == 4));
        chk("wren",     32'(bif.data_bus_wren), 32'(ph == 4 && !m_wr && legal_dest(m_dest)));
        chk("dest_err", 32'(bif.dest_err),      32'(ph == 4 && !m_wr && !legal_dest(m_dest)));
        chk("rd_wr_excl", 32'(bif.bus_rd & bif.bus_wr), 32'(0));
        if (ph == 4 && !m_wr) begin
            chk("db_data", 32'(bif.data_bus_data), 32'(m_dbd));
            if (legal_dest(m_dest))
                chk("db_req", 32'(bif.data_bus_req), 32'(m_dbr));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic drive_random();
        reset            = ($urandom_range(0, 99) == 0);
        bif.req_valid    = ($urandom_range(0, 9) < 6);
        bif.req_write    = $urandom_range(0, 1) == 1;
        bif.req_addr_sel = regfile_r16_t'($urandom_range(0, 6));
        bif.req_data_sel = regfile_r8_t'($urandom_range(0, 15));
        bif.req_dest     = ($urandom_range(0, 3) == 0) ? regfile_r8_t'($urandom_range(0, 15))
                         : (($urandom_range(0, 1) == 1) ? REG_TMP_L : REG_IR);
        bif.bus_rdata    = 8'($urandom);
        regs             = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        reset            = 1'b1;
        regs             = '0;
        bif.req_valid    = 1'b0;
        bif.req_write    = 1'b0;
        bif.req_addr_sel = REG_PC;
        bif.req_data_sel = REG_A;
        bif.req_dest     = REG_IR;
        bif.bus_rdata    = 8'h00;

        tick();
        chk("rst_ready", 32'(bif.req_ready), 32'(1));
        chk("rst_addr",  32'(bif.bus_addr), 32'(0));
        chk("rst_rd",    32'(bif.bus_rd), 32'(0));
        chk("rst_wr",    32'(bif.bus_wr), 32'(0));
        chk("rst_dbreq", 32'(bif.data_bus_req), 32'(REG_IR));
        chk("rst_dbdata",32'(bif.data_bus_data), 32'(0));
        chk("rst_wren",  32'(bif.data_bus_wren), 32'(0));
        reset = 1'b0;
        tick();

        // read to IR from PC
        regs[REG_PC_H]   = 8'h01;
        regs[REG_PC_L]   = 8'h50;
        bif.bus_rdata    = 8'h3E;
        bif.req_valid    = 1'b1;
        bif.req_write    = 1'b0;
        bif.req_addr_sel = REG_PC;
        bif.req_dest     = REG_IR;
        tick();
        bif.req_valid = 1'b0;
        chk("ir_t1_addr", 32'(bif.bus_addr), 32'h0150);
        chk("ir_t1_rd",   32'(bif.bus_rd), 32'(0));
        tick();
        chk("ir_t2_rd",   32'(bif.bus_rd), 32'(1));
        tick();
        chk("ir_t3_rd",   32'(bif.bus_rd), 32'(1));
        tick();
        chk("ir_t4_rd",   32'(bif.bus_rd), 32'(0));
        chk("ir_t4_wren", 32'(bif.data_bus_wren), 32'(1));
        chk("ir_t4_req",  32'(bif.data_bus_req), 32'(REG_IR));
        chk("ir_t4_data", 32'(bif.data_bus_data), 32'h3E);
        chk("ir_t4_done", 32'(bif.done), 32'(1));
        tick();
        chk("ir_idle_done", 32'(bif.done), 32'(0));

        // write from A to (HL), A changes mid-transaction
        regs[REG_H]      = 8'hC0;
        regs[REG_L]      = 8'h00;
        regs[REG_A]      = 8'h5A;
        bif.req_valid    = 1'b1;
        bif.req_write    = 1'b1;
        bif.req_addr_sel = REG_HL;
        bif.req_data_sel = REG_A;
        tick();
        bif.req_valid = 1'b0;
        chk("wr_t1_addr", 32'(bif.bus_addr), 32'hC000);
        chk("wr_t1_wr",   32'(bif.bus_wr), 32'(0));
        tick();
        chk("wr_t2_wr",   32'(bif.bus_wr), 32'(1));
        chk("wr_t2_data", 32'(bif.bus_wdata), 32'h5A);
        regs[REG_A] = 8'h77;
        tick();
        chk("wr_t3_data", 32'(bif.bus_wdata), 32'h5A);
        tick();
        chk("wr_t4_done", 32'(bif.done), 32'(1));
        chk("wr_t4_wren", 32'(bif.data_bus_wren), 32'(0));
        chk("wr_t4_wdata",32'(bif.bus_wdata), 32'(0));
        tick();

        // back-to-back reads with req_valid held
        regs[REG_B]      = 8'h80;
        regs[REG_C]      = 8'h00;
        bif.req_valid    = 1'b1;
        bif.req_write    = 1'b0;
        bif.req_addr_sel = REG_BC;
        bif.req_dest     = REG_TMP_L;
        tick();
        chk("b2b_t1_ready", 32'(bif.req_ready), 32'(0));
        bif.req_dest     = REG_TMP_H;
        bif.req_addr_sel = REG_DE;
        regs[REG_D]      = 8'h90;
        regs[REG_E]      = 8'h10;
        tick();
        tick();
        bif.bus_rdata = 8'h12;
        tick();
        chk("b2b_1_wren", 32'(bif.data_bus_wren), 32'(1));
        chk("b2b_1_req",  32'(bif.data_bus_req), 32'(REG_TMP_L));
        chk("b2b_1_data", 32'(bif.data_bus_data), 32'h12);
        chk("b2b_1_addr", 32'(bif.bus_addr), 32'h8000);
        tick();
        chk("b2b_2_t1_addr",  32'(bif.bus_addr), 32'h9010);
        chk("b2b_2_t1_ready", 32'(bif.req_ready), 32'(0));
        chk("b2b_2_t1_wren",  32'(bif.data_bus_wren), 32'(0));
        bif.req_valid = 1'b0;
        tick();
        tick();
        bif.bus_rdata = 8'h34;
        tick();
        chk("b2b_2_wren", 32'(bif.data_bus_wren), 32'(1));
        chk("b2b_2_req",  32'(bif.data_bus_req), 32'(REG_TMP_H));
        chk("b2b_2_data", 32'(bif.data_bus_data), 32'h34);
        tick();
        chk("b2b_idle_ready", 32'(bif.req_ready), 32'(1));

        // illegal destination
        bif.req_valid    = 1'b1;
        bif.req_addr_sel = REG_BC;
        bif.req_dest     = REG_B;
        bif.bus_rdata    = 8'h55;
        tick();
        bif.req_valid = 1'b0;
        tick();
        chk("ill_t2_rd", 32'(bif.bus_rd), 32'(1));
        tick();
        tick();
        chk("ill_t4_wren", 32'(bif.data_bus_wren), 32'(0));
        chk("ill_t4_err",  32'(bif.dest_err), 32'(1));
        chk("ill_t4_done", 32'(bif.done), 32'(1));
        tick();
        chk("ill_idle_err", 32'(bif.dest_err), 32'(0));

        // reset during T3 of a read
        bif.req_valid    = 1'b1;
        bif.req_addr_sel = REG_HL;
        bif.req_dest     = REG_IR;
        tick();
        bif.req_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rmid_ready", 32'(bif.req_ready), 32'(1));
        chk("rmid_rd",    32'(bif.bus_rd), 32'(0));
        chk("rmid_addr",  32'(bif.bus_addr), 32'(0));
        chk("rmid_wren",  32'(bif.data_bus_wren), 32'(0));
        reset = 1'b0;
        tick();
        chk("rmid_after_wren", 32'(bif.data_bus_wren), 32'(0));
        chk("rmid_after_done", 32'(bif.done), 32'(0));

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
